// File: rtl/pad_poll_transmitter.sv
// Game-pad poller and framed IR serial transmitter.
// Polls an NES/SNES style pad (latch + shift clock), captures N_BUTTONS
// button states and sends them as: preamble ones, data LSB first,
// optional even parity, one stop bit of 0, then a forced-low gap.
// All pad and serial activity advances once per divided tick.

module pad_poll_transmitter #(
    parameter int N_BUTTONS  = 8,
    parameter int DIV        = 4,
    parameter int START_BITS = 2,
    parameter int PARITY_EN  = 1,
    parameter int IDLE_GAP   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pad_data,
    output logic                 pad_latch,
    output logic                 pad_clk,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic [N_BUTTONS-1:0] buttons,
    output logic                 frame_done
);

    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STEP_W   = 8;
    localparam int TX_LEN   = START_BITS + N_BUTTONS + PARITY_EN + 1;
    localparam int READ_LEN = 2 * (N_BUTTONS - 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [STEP_W-1:0] LATCH_LAST = STEP_W'(1);
    localparam logic [STEP_W-1:0] READ_LAST  = STEP_W'(READ_LEN - 1);
    localparam logic [STEP_W-1:0] TX_LAST    = STEP_W'(TX_LEN - 1);
    localparam logic [STEP_W-1:0] GAP_LAST   = STEP_W'(IDLE_GAP - 1);
    localparam logic [STEP_W-1:0] DATA_FIRST = STEP_W'(START_BITS);
    localparam logic [STEP_W-1:0] PAR_STEP   = STEP_W'(START_BITS + N_BUTTONS);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        READ,
        TX,
        GAP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [STEP_W-1:0]    step;
    logic [STEP_W-1:0]    step_next;
    logic [STEP_W-1:0]    rd_bit;
    logic [N_BUTTONS-1:0] shift;
    logic [N_BUTTONS-1:0] shift_next;
    logic [N_BUTTONS-1:0] buttons_next;
    logic                 load_buttons;
    logic                 pad_latch_d;
    logic                 pad_clk_d;
    logic                 tx_serial_d;
    logic                 tx_busy_d;
    logic                 frame_done_d;

    // Tick divider: counts 0..DIV-1, tick on the last count (every cycle when DIV=1)
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // State and per-state step counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_next;
            step  <= step_next;
        end
    end

    // Next-state and step counter: everything advances only on tick
    always_comb begin
        state_next = state;
        step_next  = step;
        if (tick) begin
            step_next = step + STEP_W'(1);
            case (state)
                IDLE: begin
                    step_next = '0;
                    if (enable) begin
                        state_next = LATCH;
                    end
                end
                LATCH: begin
                    if (step == LATCH_LAST) begin
                        step_next = '0;
                        if (N_BUTTONS == 1) begin
                            state_next = TX;
                        end else begin
                            state_next = READ;
                        end
                    end
                end
                READ: begin
                    if (step == READ_LAST) begin
                        state_next = TX;
                        step_next  = '0;
                    end
                end
                TX: begin
                    if (step == TX_LAST) begin
                        state_next = GAP;
                        step_next  = '0;
                    end
                end
                GAP: begin
                    if (step == GAP_LAST) begin
                        state_next = IDLE;
                        step_next  = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    step_next  = '0;
                end
            endcase
        end
    end

    // READ step pairs are (high, low) phases; pair k shifts in button k+1
    assign rd_bit = {1'b0, step[STEP_W-1:1]} + STEP_W'(1);

    // Shift-in of raw (active-low) pad data: bit0 at end of latch, others at end of each clk-high phase
    always_comb begin
        shift_next = shift;
        if (tick) begin
            if (state == LATCH && step == LATCH_LAST) begin
                shift_next[0] = pad_data;
            end else if (state == READ && !step[0]) begin
                for (int unsigned i = 1; i < N_BUTTONS; i++) begin
                    if (rd_bit == STEP_W'(i)) begin
                        shift_next[i] = pad_data;
                    end
                end
            end
        end
    end

    // Captured buttons are published only when transmission starts
    always_comb begin
        load_buttons = tick && (state_next == TX) && (state != TX);
        buttons_next = buttons;
        if (load_buttons) begin
            buttons_next = ~shift_next;
        end
    end

    // Shift register for incoming pad bits
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift <= '0;
        end else begin
            shift <= shift_next;
        end
    end

    // Output decode from the upcoming state so that outputs can be registered
    // and still change on the same edge as the state update.
    always_comb begin
        pad_latch_d  = (state_next == LATCH);
        pad_clk_d    = (state_next == READ) && !step_next[0];
        tx_busy_d    = (state_next != IDLE);
        frame_done_d = tick && (state == TX) && (state_next == GAP);
        tx_serial_d  = 1'b0;
        if (state_next == TX) begin
            if (step_next < DATA_FIRST) begin
                tx_serial_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                    if (step_next == STEP_W'(START_BITS + i)) begin
                        tx_serial_d = buttons_next[i];
                    end
                end
                if (PARITY_EN != 0 && step_next == PAR_STEP) begin
                    tx_serial_d = ^buttons_next;
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b0;
            tx_serial  <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            buttons    <= '0;
        end else begin
            pad_latch  <= pad_latch_d;
            pad_clk    <= pad_clk_d;
            tx_serial  <= tx_serial_d;
            tx_busy    <= tx_busy_d;
            frame_done <= frame_done_d;
            buttons    <= buttons_next;
        end
    end

endmodule

// File: tb/tb_pad_poll_transmitter.sv
// Scoreboard bench for pad_poll_transmitter: three instances (defaults at
// DIV=4, 12-button no-parity at DIV=1, defaults at DIV=1) each driven by a
// behavioural pad model. Expected frames are queued when a poll starts and
// checked by a monitor when frame_done is seen.

module tb_pad_poll_transmitter;

    localparam int NI = 3;
    localparam int NB [NI] = '{8, 12, 8};
    localparam int DV [NI] = '{4, 1, 1};
    localparam int PE [NI] = '{1, 0, 1};
    localparam int SB = 2;
    localparam int IG = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_n;
    logic [NI-1:0] en;
    wire  [NI-1:0] pad_w;
    wire  [NI-1:0] latch_w;
    wire  [NI-1:0] pclk_w;
    wire  [NI-1:0] tx_w;
    wire  [NI-1:0] busy_w;
    wire  [NI-1:0] fd_w;

    int n_pass = 0;
    int n_tot  = 0;

    function automatic void check(input int inst, input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, inst, act, exp);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int N     = NB[g];
        localparam int D     = DV[g];
        localparam int P     = PE[g];
        localparam int L     = SB + N + P + 1;
        localparam int FRAME = 1 + 2 + 2 * (N - 1) + L + IG;

        wire [N-1:0] btn;

        pad_poll_transmitter #(
            .N_BUTTONS (N),
            .DIV       (D),
            .START_BITS(SB),
            .PARITY_EN (P),
            .IDLE_GAP  (IG)
        ) u_dut (
            .clk       (clk),
            .reset     (rst_n[g]),
            .enable    (en[g]),
            .pad_data  (pad_w[g]),
            .pad_latch (latch_w[g]),
            .pad_clk   (pclk_w[g]),
            .tx_serial (tx_w[g]),
            .tx_busy   (busy_w[g]),
            .buttons   (btn),
            .frame_done(fd_w[g])
        );

        int          idx = 0;
        logic [15:0] pressed = '0;
        int          latch_cnt = 0;
        int          fd_cnt = 0;
        int          pclk_cnt = 0;
        bit          poll_valid = 0;
        logic        rst_q = 1'b0;
        logic [15:0] exp_btn_q[$];
        logic [31:0] exp_tx_q[$];
        logic [15:0] pat_q[$];

        initial begin
            if (N == 12) begin
                pat_q.push_back(16'h0801);
            end else begin
                pat_q.push_back(16'h0001);
                pat_q.push_back(16'h00FF);
            end
        end

        // Pad model: active-low data, bit0 while latched, next bit after each clk rise
        assign pad_w[g] = (idx < N) ? ~pressed[idx[3:0]] : 1'b1;

        // Poll start: choose the pattern and queue the frame it must produce
        always @(posedge latch_w[g]) begin
            logic [15:0] p;
            logic [31:0] w;
            if (poll_valid) check(g, pclk_cnt == N - 1, "pad_clk_pulses", 64'(pclk_cnt), 64'(N - 1));
            poll_valid = 1;
            pclk_cnt = 0;
            idx = 0;
            latch_cnt++;
            if (pat_q.size() > 0) p = pat_q.pop_front();
            else p = 16'($urandom);
            p = p & 16'((1 << N) - 1);
            pressed = p;
            w = ((32'd1 << SB) - 32'd1) | (32'(p) << SB);
            if (P != 0) w = w | (32'(^p) << (SB + N));
            exp_btn_q.push_back(p);
            exp_tx_q.push_back(w);
        end

        // Pad advances to the next button on each shift clock rise
        always @(posedge pclk_w[g]) begin
            idx++;
            pclk_cnt++;
        end

        // Reset as seen by the DUT at the active edge
        always @(posedge clk) rst_q <= rst_n[g];

        logic        hist[$];
        int          cyc = 0;
        int          last_fd = 0;
        int          gap_left = 0;
        bit          have_prev = 0;
        bit          broke = 0;
        bit          gap_ok = 0;
        bit          fd_prev = 0;
        bit          idle_chk = 0;
        logic        tx_prev = 1'b0;
        logic [N-1:0] btn_prev = '0;

        // Monitor: sample away from the active edge and score frames on frame_done
        always @(negedge clk) begin
            logic [31:0] w;
            logic [15:0] eb;
            logic [31:0] got;
            int          base;
            bit          ok;
            cyc++;
            hist.push_back(tx_w[g]);
            if (hist.size() > 128) void'(hist.pop_front());
            if (!rst_q) begin
                check(g, {latch_w[g], pclk_w[g], tx_w[g], busy_w[g], fd_w[g]} == 5'b0 && btn == '0,
                      "reset_state", {latch_w[g], pclk_w[g], tx_w[g], busy_w[g], fd_w[g], 16'(btn)}, 64'd0);
                poll_valid = 0;
                exp_btn_q.delete();
                exp_tx_q.delete();
                have_prev = 0;
                gap_left = 0;
                fd_prev = 0;
                idle_chk = 0;
            end else begin
                if (!en[g]) broke = 1;
                if (fd_prev) check(g, fd_w[g] == 1'b0, "frame_done_width", 64'(fd_w[g]), 64'd0);
                if (idle_chk) begin
                    check(g, !busy_w[g] && !tx_w[g] && !latch_w[g], "idle_after_gap",
                          {busy_w[g], tx_w[g], latch_w[g]}, 64'd0);
                    idle_chk = 0;
                end
                if (gap_left > 0) begin
                    if (!(tx_w[g] == 1'b0 && busy_w[g] == 1'b1)) gap_ok = 0;
                    gap_left--;
                    if (gap_left == 0) begin
                        check(g, gap_ok, "gap_low_busy", 64'(gap_ok), 64'd1);
                        idle_chk = 1;
                    end
                end
                if (btn != btn_prev)
                    check(g, tx_w[g] && !tx_prev, "buttons_change_at_tx_start", {tx_prev, tx_w[g]}, 64'b01);
                if (fd_w[g]) begin
                    fd_cnt++;
                    if (exp_tx_q.size() == 0) begin
                        check(g, 1'b0, "frame_expected", 64'd0, 64'd1);
                    end else begin
                        w = exp_tx_q.pop_front();
                        eb = exp_btn_q.pop_front();
                        ok = 1;
                        got = '0;
                        base = hist.size() - 1 - L * D;
                        for (int s = 0; s < L; s++) begin
                            got[s[4:0]] = hist[base + s * D];
                            for (int k = 0; k < D; k++)
                                if (hist[base + s * D + k] !== w[s[4:0]]) ok = 0;
                        end
                        if (hist[base - 1] !== 1'b0 || hist[hist.size() - 1] !== 1'b0) ok = 0;
                        check(g, ok, "tx_frame", 64'(got), 64'(w));
                        check(g, btn === eb[N-1:0], "buttons", 64'(btn), 64'(eb));
                    end
                    if (have_prev && !broke)
                        check(g, cyc - last_fd == FRAME * D, "frame_spacing", 64'(cyc - last_fd), 64'(FRAME * D));
                    have_prev = 1;
                    broke = 0;
                    last_fd = cyc;
                    gap_left = IG * D - 1;
                    gap_ok = (tx_w[g] == 1'b0 && busy_w[g] == 1'b1);
                end
                fd_prev = fd_w[g];
            end
            btn_prev = btn;
            tx_prev = tx_w[g];
        end
    end

    task automatic wait_latch_rise(input int g, input int limit);
        logic prev;
        bit   found;
        prev = latch_w[g];
        found = 0;
        for (int c = 0; c < limit && !found; c++) begin
            @(posedge clk);
            #1;
            if (latch_w[g] && !prev) found = 1;
            prev = latch_w[g];
        end
        check(g, found, "latch_rise_timeout", 64'(found), 64'd1);
    endtask

    task automatic wait_fd0(input int target, input int limit);
        for (int c = 0; c < limit && g_inst[0].fd_cnt < target; c++) @(posedge clk);
        #1;
        check(0, g_inst[0].fd_cnt >= target, "frame_done_timeout", 64'(g_inst[0].fd_cnt), 64'(target));
    endtask

    initial begin
        int first [NI];
        int c0;
        int f0;
        int l0;
        rst_n = '0;
        en = '0;
        for (int g = 0; g < NI; g++) first[g] = 0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = '1;
        en = '1;

        // First latch rise must land on the edge ending cycle DIV
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < NI; g++)
                if (latch_w[g] && first[g] == 0) first[g] = c;
        end
        for (int g = 0; g < NI; g++)
            check(g, first[g] == DV[g], "first_latch_cycle", 64'(first[g]), 64'(DV[g]));

        // Directed frames 0x01 then 0xFF on instance 0
        wait_fd0(2, 600);

        // Reset during the fifth TX bit of instance 0
        wait_latch_rise(0, 400);
        repeat (80) @(posedge clk);
        #1;
        check(0, busy_w[0] == 1'b1, "busy_before_reset", 64'(busy_w[0]), 64'd1);
        rst_n[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        c0 = 0;
        for (int c = 1; c <= 32 && c0 == 0; c++) begin
            @(posedge clk);
            #1;
            if (latch_w[0]) c0 = c;
        end
        check(0, c0 == DV[0], "latch_after_reset", 64'(c0), 64'(DV[0]));
        wait_fd0(g_inst[0].fd_cnt + 1, 400);

        // Drop enable during READ: frame completes once, then the pad goes quiet
        wait_latch_rise(0, 400);
        repeat (12) @(posedge clk);
        #1;
        en[0] = 1'b0;
        f0 = g_inst[0].fd_cnt;
        l0 = g_inst[0].latch_cnt;
        repeat (3 * 148) @(posedge clk);
        #1;
        check(0, g_inst[0].fd_cnt == f0 + 1, "frames_after_disable", 64'(g_inst[0].fd_cnt), 64'(f0 + 1));
        check(0, g_inst[0].latch_cnt == l0, "latches_after_disable", 64'(g_inst[0].latch_cnt), 64'(l0));
        check(0, busy_w[0] == 1'b0, "idle_when_disabled", 64'(busy_w[0]), 64'd0);
        en[0] = 1'b1;
        wait_fd0(f0 + 3, 600);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pad_poll_transmitter.md
# pad_poll_transmitter

Parametrised game-pad poller and serial frame transmitter for the wireless remote. It drives the pad's latch and clock lines at a divided rate and shifts in N_BUTTONS button states. It then sends them on the IR serial line as a framed packet: preamble, data, optional even parity and stop bit. It supersedes the fixed 8-button counter/decoder scheme and supports NES (8) and SNES (12/16) pads, configurable timing, and a per-frame completion flag.

## Interface
- N_BUTTONS, 8, buttons read per poll (1..16)
- DIV, 4, clk cycles per tick; all pad and serial activity advances once per tick (1..256)
- START_BITS, 2, preamble ones sent before data (1..4)
- PARITY_EN, 1, 1 = append even-parity bit over data bits, 0 = omit
- IDLE_GAP, 8, ticks of forced-low serial line after each frame (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- enable  in  1  1 = poll continuously; sampled only in IDLE
- pad_data  in  1  pad serial data, active-low (0 = pressed)
- pad_latch  out  1  pad latch strobe
- pad_clk  out  1  pad shift clock
- tx_serial  out  1  IR serial data
- tx_busy  out  1  high in LATCH/READ/TX/GAP
- buttons  out  N_BUTTONS  last captured states, active-high, bit0 = first button shifted out
- frame_done  out  1  one-clk pulse on entry to GAP

## Operation
- Tick generator: div_cnt counts 0..DIV-1 and wraps. tick = (div_cnt == DIV-1). With DIV=1, tick is high every cycle.
- All state and bit counters advance only on tick cycles.
- FSM states: IDLE, LATCH, READ, TX, GAP.
- IDLE: all pad and serial outputs 0. On tick with enable=1, go to LATCH. Otherwise stay.
- LATCH: pad_latch=1 for 2 ticks. On the second tick, sample pad_data into shift bit0 and go to READ. If N_BUTTONS=1, go directly to TX.
- READ: for bits 1..N_BUTTONS-1, pad_clk is high for 1 tick, then low for 1 tick.
  - Sample pad_data on the tick ending each high phase.
  - After the low phase of the last bit, load buttons <= ~shift and go to TX.
  - READ lasts 2*(N_BUTTONS-1) ticks.
- TX: one bit per tick. tx_serial sends, in order:
  - START_BITS ones
  - buttons[0..N_BUTTONS-1], LSB first
  - the parity bit if PARITY_EN (XOR of buttons, so total ones in the data plus parity is even)
  - one stop bit of 0
  - then go to GAP.
- GAP: tx_serial=0 for IDLE_GAP ticks, then go to IDLE.
- enable deasserted mid-frame: the frame completes normally, and the FSM then rests in IDLE.
- buttons changes only at the READ→TX transition. It holds its value in every other state.
- Reset (reset=0 at a clk edge) aborts any state immediately and clears:
  - state = IDLE and div_cnt = 0
  - all outputs and buttons = 0, with tx_busy = 0.

## Timing
- Outputs are registered, with no combinational path from inputs to outputs.
- Outputs change on the same clk edge as the state/bit-counter update, i.e. the edge where tick=1.
- Reset values: pad_latch=0, pad_clk=0, tx_serial=0, tx_busy=0, frame_done=0, buttons=0.
- Frame length in ticks: 1 (IDLE) + 2 + 2(N_BUTTONS-1) + START_BITS + N_BUTTONS + PARITY_EN + 1 + IDLE_GAP.
  - Defaults: 1+2+14+2+8+1+1+8 = 37 ticks = 148 clk.
- With enable held high, frame_done pulses are exactly one frame length apart.
- frame_done is high for exactly one clk cycle, regardless of DIV.
- First pad_latch rise after reset release with enable=1: the edge ending clk cycle DIV (first tick).
- Minimum pad_latch and pad_clk high width: 2*DIV and DIV clk respectively.

## Test plan
- Defaults; enable=1; pad presses only button0 (pad_data low while bit0 is presented).
  - Required: buttons=8'h01.
  - tx_serial sequence per tick: 1,1,1,0,0,0,0,0,0,0,1(parity),0(stop), then 8 ticks of 0.
- Defaults; all buttons pressed.
  - Required: buttons=8'hFF, parity bit 0, frame_done spacing 148 clk.
- Defaults; assert reset=0 during the 5th TX bit.
  - Required: next edge gives all outputs 0 and tx_busy 0.
  - After release: first pad_latch rise at clk DIV, and a full fresh frame follows.
- Defaults; drop enable during READ.
  - Required: the current frame transmits completely and frame_done pulses once.
  - No further pad_latch while enable=0; buttons holds its value.
- N_BUTTONS=12, PARITY_EN=0, DIV=1; buttons 0 and 11 pressed.
  - Required: 11 pad_clk pulses per poll and buttons=12'h801.
  - TX is 15 ticks: 1,1,1,0×10,1,0.
- DIV=1 vs DIV=4 with the same stimulus.
  - Required: identical tick-level waveforms, time-scaled ×4.
